// File: rtl/b_bus_pkg.sv
// Shared definitions for the B-bus source multiplexer: source indices,
// kernel run length and controller state encoding.
package b_bus_pkg;

    localparam int SRC_MDR  = 0;
    localparam int SRC_K0   = 1;
    localparam int SRC_K1   = 2;
    localparam int SRC_K2   = 3;
    localparam int SRC_K3   = 4;
    localparam int SRC_K4   = 5;
    localparam int SRC_K5   = 6;
    localparam int SRC_K6   = 7;
    localparam int SRC_K7   = 8;
    localparam int SRC_K8   = 9;
    localparam int SRC_P1   = 10;
    localparam int SRC_P2   = 11;
    localparam int SRC_P3   = 12;
    localparam int SRC_DP   = 13;
    localparam int SRC_CV   = 14;
    localparam int SRC_I    = 15;
    localparam int SRC_MBRU = 16;

    localparam int KERNEL_LEN = 9;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } bus_state_e;

endpackage

// File: rtl/b_bus_out_reg.sv
// Output holding register for the B bus: data plus source index, with a
// valid/ready stage that holds its contents while the consumer stalls.
module b_bus_out_reg
    import b_bus_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [SEL_W-1:0] ld_src,
    input  logic             y_ready,
    output logic [WIDTH-1:0] y,
    output logic [SEL_W-1:0] y_src,
    output logic             y_valid,
    output logic             load_ok
);

    logic [WIDTH-1:0] y_r;
    logic [SEL_W-1:0] y_src_r;
    logic             y_valid_r;

    // Beat register: load a new beat, retire a consumed one, or hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r       <= {WIDTH{1'b0}};
            y_src_r   <= {SEL_W{1'b0}};
            y_valid_r <= 1'b0;
        end else if (load) begin
            y_r       <= ld_data;
            y_src_r   <= ld_src;
            y_valid_r <= 1'b1;
        end else if (y_ready) begin
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= y_valid_r;
        end
    end

    assign load_ok = !y_valid_r || y_ready;
    assign y       = y_r;
    assign y_src   = y_src_r;
    assign y_valid = y_valid_r;

endmodule

// File: rtl/b_bus_mux_seq.sv
// Registered B-bus source multiplexer with single-beat requests and a
// burst mode that streams consecutive source indices onto the bus.
module b_bus_mux_seq
    import b_bus_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 17,
    parameter int SEL_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] src_flat,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     sel_valid,
    output logic                     sel_ready,
    input  logic                     burst_start,
    input  logic [SEL_W-1:0]         burst_base,
    input  logic [SEL_W-1:0]         burst_len,
    output logic [WIDTH-1:0]         y,
    output logic                     y_valid,
    output logic [SEL_W-1:0]         y_src,
    input  logic                     y_ready,
    output logic                     busy,
    output logic                     err_sel,
    input  logic                     err_clr
);

    bus_state_e       state_r, next_state_s;
    logic [SEL_W-1:0] idx_r;
    logic [SEL_W-1:0] rem_r;
    logic             err_r;

    logic             load_ok_s;
    logic             load_s;
    logic             burst_go_s;
    logic             sel_ready_s;
    logic             illegal_s;
    logic [SEL_W-1:0] load_idx_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [WIDTH-1:0] src_arr_s [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src_arr_s[g] = src_flat[g*WIDTH +: WIDTH];
    end

    // Next-state, handshake and load decision.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        load_idx_s   = idx_r;
        burst_go_s   = 1'b0;
        sel_ready_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sel_ready_s = load_ok_s && !burst_start;
                if (burst_start && (burst_len != {SEL_W{1'b0}})) begin
                    next_state_s = ST_BURST;
                    burst_go_s   = 1'b1;
                end else if (sel_valid && sel_ready_s) begin
                    load_s     = 1'b1;
                    load_idx_s = sel;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_BURST: begin
                if (load_ok_s) begin
                    load_s     = 1'b1;
                    load_idx_s = idx_r;
                    if (rem_r == SEL_W'(1)) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_BURST;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Indices past the last source read as zero and raise the error flag.
    always_comb begin
        illegal_s = ({1'b0, load_idx_s} >= (SEL_W+1)'(NUM_SRC));
        if (illegal_s) begin
            sel_data_s = {WIDTH{1'b0}};
        end else begin
            sel_data_s = src_arr_s[load_idx_s];
        end
    end

    // Controller state, burst counters and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {SEL_W{1'b0}};
            rem_r   <= {SEL_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (burst_go_s) begin
                idx_r <= burst_base;
                rem_r <= burst_len;
            end else if (load_s && (state_r == ST_BURST)) begin
                idx_r <= idx_r + SEL_W'(1);
                rem_r <= rem_r - SEL_W'(1);
            end else begin
                idx_r <= idx_r;
                rem_r <= rem_r;
            end
            // set beats clear when both happen on the same edge
            if (load_s && illegal_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    b_bus_out_reg #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .ld_data (sel_data_s),
        .ld_src  (load_idx_s),
        .y_ready (y_ready),
        .y       (y),
        .y_src   (y_src),
        .y_valid (y_valid),
        .load_ok (load_ok_s)
    );

    assign sel_ready = sel_ready_s;
    assign busy      = (state_r == ST_BURST);
    assign err_sel   = err_r;

endmodule
